// File: rtl/synth_pkg.sv
// Shared types and sizes for the voice allocator slice.
package synth_pkg;

  localparam int unsigned NUM_VOICES = 4;
  localparam int unsigned NUM_KEYS   = 13;

  typedef logic [3:0] note_t;
  typedef logic [1:0] rank_t;
  typedef logic [1:0] voice_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_COMMIT = 2'd2
  } alloc_state_t;

  // Index of the lowest set bit; zero when no bit is set.
  function automatic note_t lowest_set(input logic [NUM_KEYS-1:0] bits);
    note_t idx;
    idx = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (bits[i]) idx = note_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_event_latch.sv
// Registers the key levels, detects press/release edges and keeps them as
// sticky pending bits until the allocator services them.
module key_event_latch
  import synth_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] i_keys,
  input  logic [NUM_KEYS-1:0] i_clr_press,
  input  logic [NUM_KEYS-1:0] i_clr_rel,
  output logic [NUM_KEYS-1:0] o_press_pend,
  output logic [NUM_KEYS-1:0] o_rel_pend
);

  logic [NUM_KEYS-1:0] r_keys;
  logic [NUM_KEYS-1:0] r_keys_prev;
  logic [NUM_KEYS-1:0] w_press_ev;
  logic [NUM_KEYS-1:0] w_rel_ev;

  assign w_press_ev = r_keys & ~r_keys_prev;
  assign w_rel_ev   = ~r_keys & r_keys_prev;

  // A fresh edge beats a same-cycle service clear; the opposite edge cancels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_keys       <= '0;
      r_keys_prev  <= '0;
      o_press_pend <= '0;
      o_rel_pend   <= '0;
    end else begin
      r_keys       <= i_keys;
      r_keys_prev  <= r_keys;
      o_press_pend <= (o_press_pend & ~i_clr_press & ~w_rel_ev) | w_press_ev;
      o_rel_pend   <= (o_rel_pend & ~i_clr_rel & ~w_press_ev) | w_rel_ev;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Four-voice allocator: services one key event every three cycles, releases
// first, stealing the oldest voice when all voices are busy.
module voice_allocator
  import synth_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_KEYS-1:0]   keys,
  output logic [NUM_VOICES-1:0] voice_active,
  output note_t [NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0] voice_start,
  output logic [NUM_VOICES-1:0] voice_stop
);

  alloc_state_t          r_state;
  alloc_state_t          w_state_next;
  rank_t [NUM_VOICES-1:0] r_rank;

  logic [NUM_KEYS-1:0] w_press_pend;
  logic [NUM_KEYS-1:0] w_rel_pend;
  logic [NUM_KEYS-1:0] w_clr_press;
  logic [NUM_KEYS-1:0] w_clr_rel;

  logic   w_have;
  logic   w_is_rel;
  logic   w_do_sel;
  logic   w_rel_hit;
  note_t  w_note;
  voice_t w_rel_voice;
  voice_t w_press_voice;

  key_event_latch u_key_event_latch (
    .clk          (clk),
    .rst          (rst),
    .i_keys       (keys),
    .i_clr_press  (w_clr_press),
    .i_clr_rel    (w_clr_rel),
    .o_press_pend (w_press_pend),
    .o_rel_pend   (w_rel_pend)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_have) w_state_next = ST_SELECT;
      ST_SELECT: w_state_next = ST_COMMIT;
      ST_COMMIT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Event selection and voice lookup; scans run high-to-low so the lowest index wins.
  always_comb begin
    w_have        = (|w_press_pend) || (|w_rel_pend);
    w_is_rel      = |w_rel_pend;
    w_note        = w_is_rel ? lowest_set(w_rel_pend) : lowest_set(w_press_pend);
    w_do_sel      = (r_state == ST_SELECT) && w_have;
    w_rel_hit     = 1'b0;
    w_rel_voice   = '0;
    w_press_voice = '0;
    w_clr_press   = '0;
    w_clr_rel     = '0;
    for (int v = int'(NUM_VOICES) - 1; v >= 0; v--) begin
      if (voice_active[v] && (voice_note[v] == w_note)) begin
        w_rel_hit   = 1'b1;
        w_rel_voice = voice_t'(v);
      end
      if (r_rank[v] == rank_t'(NUM_VOICES - 1)) w_press_voice = voice_t'(v);
    end
    for (int v = int'(NUM_VOICES) - 1; v >= 0; v--) begin
      if (!voice_active[v]) w_press_voice = voice_t'(v);
    end
    if (w_do_sel) begin
      if (w_is_rel) w_clr_rel[w_note]   = 1'b1;
      else          w_clr_press[w_note] = 1'b1;
    end
  end

  // Voice table and pulses update on the SELECT->COMMIT edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      voice_active <= '0;
      voice_note   <= '0;
      voice_start  <= '0;
      voice_stop   <= '0;
      for (int v = 0; v < int'(NUM_VOICES); v++) r_rank[v] <= rank_t'(v);
    end else begin
      voice_start <= '0;
      voice_stop  <= '0;
      if (w_do_sel) begin
        if (w_is_rel) begin
          if (w_rel_hit) begin
            voice_active[w_rel_voice] <= 1'b0;
            voice_stop[w_rel_voice]   <= 1'b1;
          end
        end else begin
          voice_active[w_press_voice] <= 1'b1;
          voice_note[w_press_voice]   <= w_note;
          voice_start[w_press_voice]  <= 1'b1;
          for (int v = 0; v < int'(NUM_VOICES); v++) begin
            if (voice_t'(v) == w_press_voice)
              r_rank[v] <= '0;
            else if (r_rank[v] < r_rank[w_press_voice])
              r_rank[v] <= rank_t'(r_rank[v] + 2'd1);
          end
        end
      end
    end
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; all other ports are synchronous to clk.
REQ-002 clk  input  1  system clock, 10 MHz.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 keys  input  13  synchronized key levels; bit i = note i, 1 = held.
REQ-005 voice_active  output  4  bit v = voice v is sounding.
REQ-006 voice_note  output  4x4  note index 0-12 assigned to each voice.
REQ-007 voice_start  output  4  one-cycle pulse; restart phase and envelope of voice v.
REQ-008 voice_stop  output  4  one-cycle pulse; begin release of voice v.

Function
REQ-009 keys SHALL be registered once; a press event is prev=0,cur=1; a release event is prev=1,cur=0.
REQ-010 Events SHALL set sticky bits in press_pend[12:0] / rel_pend[12:0]; a bit clears only when its event is serviced.
REQ-011 A new press on note i SHALL clear rel_pend[i], and a new release on note i SHALL clear press_pend[i], so the net key state wins.
REQ-012 The FSM SHALL have the states IDLE, SELECT and COMMIT.
REQ-013 IDLE -> SELECT when any pending bit is set; SELECT -> COMMIT always; COMMIT -> IDLE always.
REQ-014 SELECT SHALL pick exactly one event: any release before any press, with the lowest note index first inside each class.
REQ-015 A serviced release SHALL find the voice whose voice_note equals the note and voice_active=1, clear voice_active, and pulse voice_stop for that voice in COMMIT.
REQ-016 If no voice holds that note (stolen earlier), the release SHALL be dropped with no output change.
REQ-017 A serviced press SHALL use the lowest-index inactive voice, or steal the voice with age rank 3 when all voices are active.
REQ-018 On a press, the chosen voice SHALL get the note and voice_active=1, and voice_start SHALL pulse for it in COMMIT.
REQ-019 A stolen voice SHALL pulse only voice_start, never voice_stop.
REQ-020 Age ranks 0..3 SHALL be a permutation of the voices, with 0 the newest.
REQ-021 On assignment, the chosen voice SHALL take rank 0 and every voice with a lower old rank SHALL increment its rank; releases do not change ranks.
REQ-022 Latency: with no other events pending, voice_start/voice_stop SHALL be high during the 4th cycle after the key is first sampled changed (IDLE at event +2, SELECT at +3, COMMIT at +4).
REQ-023 Events arriving while the FSM is busy SHALL be queued, with none lost; throughput is one event per 3 cycles.
REQ-024 At most one bit of voice_start|voice_stop SHALL be high in any cycle.

Reset
REQ-025 Asserting rst at any time SHALL immediately set FSM=IDLE, pending=0, the registered keys=0, voice_active=0, voice_note=0, voice_start=0 and voice_stop=0.
REQ-026 Reset SHALL set the age ranks to voice v = rank v.
REQ-027 After rst is released, keys already held SHALL generate press events.

Structure
REQ-028 The shared package synth_pkg SHALL hold NUM_VOICES=4, NUM_KEYS=13, note_t (logic[3:0]), rank_t (logic[1:0]) and the FSM state enum alloc_state_t.
REQ-029 The edge detection and sticky pending logic SHALL be the sub-module key_event_latch, instantiated once.
REQ-030 All outputs SHALL be driven directly from flops.

Verification
REQ-031 Reset: hold rst during 2 clocks with keys=13'h1FFF -> all outputs 0; release rst -> voices 0-3 receive notes 0,1,2,3 in that order, 3 cycles apart.
REQ-032 Single press/release: keys bit 5 rises -> voice_start=4'b0001 and voice_note[0]=5 at latency 4; bit 5 falls -> voice_stop=4'b0001 and voice_active=0.
REQ-033 Steal: press notes 0,1,2,3 one after another, then 7 -> voice 0 takes note 7 with voice_start=4'b0001 and no voice_stop; then release note 0 -> no output pulse.
REQ-034 Priority: in one cycle release note 1 (on voice 1) and press note 9 while all voices are busy -> voice_stop=4'b0010 first, then note 9 goes to the free voice 1 with no steal.
REQ-035 Burst: 13 keys rise at the same time from idle -> 13 events serviced in index order, one every 3 cycles; the final voice_note for voices 0-3 is {12,9,10,11}.
REQ-036 Mid-operation reset: assert rst during SELECT with 3 events pending -> outputs clear at once with no pulse afterwards, and held keys are then re-serviced.
